// File: rtl/mc_controller_if.sv
// ---------------------------------------------------------------------------
// mc_controller_if
//   Bundles the instruction fields, ALU zero flag and every datapath control
//   strobe exchanged between the multicycle MIPS control unit and its datapath.
//   Modports:
//     master : control unit side (reads op/funct/zero, drives controls)
//     slave  : datapath side (drives op/funct/zero, reads controls)
//   Signals:
//     op[5:0], funct[5:0], zero             instruction fields / ALU flag
//     pcen, memwrite, irwrite, regwrite     write enables
//     iord, memtoreg, regdst, alusrca       1-bit mux selects
//     alusrcb[1:0], pcsrc[1:0]              2-bit mux selects
//     alucontrol[2:0]                       ALU function code
//     state_o[3:0]                          current FSM state (debug)
// ---------------------------------------------------------------------------
interface mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, state_o
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, pcsrc, alucontrol, state_o
  );
endinterface

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
//   Main control unit of the multicycle MIPS core: a Moore FSM that sequences
//   fetch / decode / execute / memory / writeback and an ALU decoder that
//   produces the 3-bit ALU function code (010 add, 110 sub, 000 and, 001 or,
//   111 slt). The ALU zero flag resolves branches in the same cycle.
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-high; returns the FSM to FETCH and gates
//             all write enables low while asserted
//     bus   : mc_controller_if.master (instruction fields, zero flag,
//             datapath controls, state_o)
//   Configuration:
//     MC_CTRL_BNE_EN : when defined, op 000101 (bne) is executed through the
//                      BEQEX state with the branch sense inverted. When
//                      undefined, bne is treated as an illegal opcode.
// ---------------------------------------------------------------------------
module mc_controller (
  input  logic             clk,
  input  logic             reset,
  mc_controller_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;   // unknown R-type funct seen in RTYPEEX

  logic       pcwrite;
  logic       branch;
  logic       take;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       regwrite_raw;
  logic [2:0] funct_alu;
  logic       funct_bad;

  // ------------------------------------------------------------------------
  // State and flag registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef MC_CTRL_BNE_EN
  // Remembers whether the instruction in flight is bne so BEQEX can invert
  // the branch condition; captured while the opcode is being decoded.
  logic ne_q, ne_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      ne_q <= 1'b0;
    end else begin
      ne_q <= ne_d;
    end
  end

  always_comb begin
    ne_d = ne_q;
    if (state_q == DECODE) begin
      ne_d = (bus.op == OP_BNE);
    end
  end

  assign take = bus.zero ^ ne_q;
`else
  assign take = bus.zero;
`endif

  // ------------------------------------------------------------------------
  // R-type funct decode
  // ------------------------------------------------------------------------
  always_comb begin
    funct_alu = 3'b010;
    funct_bad = 1'b0;
    case (bus.funct)
      6'b100000: funct_alu = 3'b010;   // add
      6'b100010: funct_alu = 3'b110;   // sub
      6'b100100: funct_alu = 3'b000;   // and
      6'b100101: funct_alu = 3'b001;   // or
      6'b101010: funct_alu = 3'b111;   // slt
      default:   funct_bad = 1'b1;     // executes as add, writeback dropped
    endcase
  end

  // ------------------------------------------------------------------------
  // Next state and Moore outputs
  // ------------------------------------------------------------------------
  always_comb begin
    state_d         = FETCH;
    illegal_d       = illegal_q;
    pcwrite         = 1'b0;
    branch          = 1'b0;
    memwrite_raw    = 1'b0;
    irwrite_raw     = 1'b0;
    regwrite_raw    = 1'b0;
    bus.iord        = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regdst      = 1'b0;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.pcsrc       = 2'b00;
    bus.alucontrol  = 3'b000;

    case (state_q)
      FETCH: begin
        illegal_d      = 1'b0;
        irwrite_raw    = 1'b1;
        bus.alusrcb    = 2'b01;
        bus.alucontrol = 3'b010;
        pcwrite        = 1'b1;
        state_d        = DECODE;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut for a possible beq.
        bus.alusrcb    = 2'b11;
        bus.alucontrol = 3'b010;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = BEQEX;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;   // skipped; PC already advanced
        endcase
      end
      MEMADR: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = 2'b10;
        bus.alucontrol = 3'b010;
        state_d        = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.iord = 1'b1;
        state_d  = MEMWB;
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite_raw = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        bus.iord     = 1'b1;
        memwrite_raw = 1'b1;
        state_d      = FETCH;
      end
      RTYPEEX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = funct_alu;
        illegal_d      = funct_bad;
        state_d        = RTYPEWB;
      end
      RTYPEWB: begin
        bus.regdst   = 1'b1;
        regwrite_raw = ~illegal_q;
        state_d      = FETCH;
      end
      BEQEX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = 3'b110;
        bus.pcsrc      = 2'b01;
        branch         = 1'b1;
        state_d        = FETCH;
      end
      ADDIEX: begin
        bus.alusrca    = 1'b1;
        bus.alusrcb    = 2'b10;
        bus.alucontrol = 3'b010;
        state_d        = ADDIWB;
      end
      ADDIWB: begin
        regwrite_raw = 1'b1;
        state_d      = FETCH;
      end
      JEX: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
        state_d   = FETCH;
      end
      default: begin
        state_d = FETCH;   // unused codes recover with everything idle
      end
    endcase
  end

  // Write enables are held low for the whole reset cycle so an instruction
  // interrupted by reset never commits a partial write.
  assign bus.memwrite = memwrite_raw & ~reset;
  assign bus.irwrite  = irwrite_raw  & ~reset;
  assign bus.regwrite = regwrite_raw & ~reset;
  assign bus.pcen     = (pcwrite | (branch & take)) & ~reset;
  assign bus.state_o  = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller
//   Self-checking bench for mc_controller. Each instruction is modelled as the
//   list of states it walks through; the expected controls for every cycle
//   come from a table of the documented per-state outputs. Opcodes, funct
//   codes and the zero flag are randomized; funct is scrambled outside
//   RTYPEEX so the latched illegal-funct flag is exercised.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mc_controller;

  typedef int int_q_t[$];

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   instr_cnt;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MC_CTRL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // States visited by one instruction, starting at FETCH.
  function automatic int_q_t state_seq(input logic [5:0] op);
    int_q_t s;
    s = '{0, 1};
    case (op)
      6'b100011: s = '{0, 1, 2, 3, 4};
      6'b101011: s = '{0, 1, 2, 5};
      6'b000000: s = '{0, 1, 6, 7};
      6'b000100: s = '{0, 1, 8};
      6'b001000: s = '{0, 1, 9, 10};
      6'b000010: s = '{0, 1, 11};
      6'b000101: if (BNE_EN) s = '{0, 1, 8};
      default:   s = '{0, 1};
    endcase
    return s;
  endfunction

  // Expected control word:
  // {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol}
  function automatic logic [14:0] exp_ctrl(input int st, input logic [5:0] op,
                                           input logic [5:0] fn, input logic z,
                                           input logic rst);
    logic pcen, mw, irw, rw, iord, m2r, rdst, asa;
    logic [1:0] asb, psrc;
    logic [2:0] alu;
    logic legal;
    {pcen, mw, irw, rw, iord, m2r, rdst, asa} = '0;
    asb = 2'b00; psrc = 2'b00; alu = 3'b000;
    legal = 1'b1;
    case (fn)
      6'h20: alu = 3'b010;
      6'h22: alu = 3'b110;
      6'h24: alu = 3'b000;
      6'h25: alu = 3'b001;
      6'h2a: alu = 3'b111;
      default: begin alu = 3'b010; legal = 1'b0; end
    endcase
    if (st != 6) alu = 3'b000;
    case (st)
      0:  begin irw = 1; asb = 2'b01; alu = 3'b010; pcen = 1; end
      1:  begin asb = 2'b11; alu = 3'b010; end
      2:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  asa = 1;
      7:  begin rdst = 1; rw = legal; end
      8:  begin asa = 1; alu = 3'b110; psrc = 2'b01;
                pcen = z ^ (BNE_EN && op == 6'b000101); end
      9:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      10: rw = 1;
      11: begin psrc = 2'b10; pcen = 1; end
      default: ;
    endcase
    if (rst) begin pcen = 0; mw = 0; irw = 0; rw = 0; end
    return {pcen, mw, irw, rw, iord, m2r, rdst, asa, asb, psrc, alu};
  endfunction

  function automatic logic [14:0] dut_ctrl();
    return {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord,
            bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc,
            bus.alucontrol};
  endfunction

  // Runs one instruction. zmode: 0 zero=0, 1 zero=1, 2 random.
  // rst_step >= 0 asserts reset for two cycles at that step and abandons
  // the rest of the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int rst_step);
    int_q_t seq;
    int     cycles;
    logic   z;
    seq = state_seq(op);
    cycles = 0;
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge clk);
      reset = 1'b0;
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.op    = op;
      bus.zero  = z;
      bus.funct = (seq[i] == 6) ? fn : 6'($urandom);
      if (i == rst_step) begin
        reset = 1'b1;
        #1;
        check_eq("rst_state_hold", 32'(bus.state_o), 32'(seq[i]));
        check_eq("rst_ctrl_gated", 32'(dut_ctrl()), 32'(exp_ctrl(seq[i], op, fn, z, 1'b1)));
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_state_fetch", 32'(bus.state_o), 32'd0);
        check_eq("rst_fetch_gated", 32'(dut_ctrl()), 32'(exp_ctrl(0, op, fn, bus.zero, 1'b1)));
        @(posedge clk);
        $display("instr %0d op=%b funct=%b reset at step %0d", instr_cnt, op, fn, i);
        instr_cnt++;
        return;
      end
      #1;
      check_eq($sformatf("state_op%b_s%0d", op, i), 32'(bus.state_o), 32'(seq[i]));
      check_eq($sformatf("ctrl_op%b_st%0d", op, seq[i]), 32'(dut_ctrl()),
               32'(exp_ctrl(seq[i], op, fn, z, 1'b0)));
      cycles++;
      @(posedge clk);
    end
    $display("instr %0d op=%b funct=%b cycles=%0d", instr_cnt, op, fn, cycles);
    instr_cnt++;
  endtask

  localparam logic [5:0] OPS [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                     6'b001000, 6'b000010, 6'b000101, 6'b111111};
  localparam logic [5:0] FNS [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};

  initial begin
    logic [5:0] op, fn;
    checks = 0; errors = 0; instr_cnt = 0;
    reset = 1'b1;
    bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("reset_state", 32'(bus.state_o), 32'd0);
    check_eq("reset_enables", 32'({bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite}), 32'd0);

    // Directed cases
    run_instr(6'b000000, 6'h2a, 2, 3);     // reset while in RTYPEWB
    run_instr(6'b100011, 6'h20, 2, -1);    // lw
    run_instr(6'b101011, 6'h20, 2, -1);    // sw
    run_instr(6'b000000, 6'h2a, 2, -1);    // slt
    run_instr(6'b000000, 6'h3f, 2, -1);    // illegal funct
    run_instr(6'b000100, 6'h00, 1, -1);    // beq taken
    run_instr(6'b000100, 6'h00, 0, -1);    // beq not taken
    run_instr(6'b000010, 6'h00, 2, -1);    // j
    run_instr(6'b111111, 6'h00, 2, -1);    // illegal op
    run_instr(6'b000101, 6'h00, 0, -1);    // bne, zero=0
    run_instr(6'b000101, 6'h00, 1, -1);    // bne, zero=1
    run_instr(6'b101011, 6'h20, 2, 3);     // reset in MEMWR

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      op = OPS[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      fn = FNS[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
      run_instr(op, fn, 2, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
